// File: rtl/bank_req_sequencer.sv
// In-order request front-end for multi_bank_memory: queues client requests,
// issues them one per cycle on the memory port and returns read data.
module bank_req_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_BANKS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [$clog2(NUM_BANKS)-1:0] req_bank,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]        req_data,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_din,
  output logic [$clog2(NUM_BANKS)-1:0] mem_bank_sel,
  input  logic [DATA_WIDTH-1:0]        mem_dout,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [$clog2(NUM_BANKS)-1:0] rsp_bank,
  output logic [ADDR_WIDTH-1:0]        rsp_addr,
  output logic                         busy
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic                  fifo_we_q   [FIFO_DEPTH];
  logic [BANK_W-1:0]     fifo_bank_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic [BANK_W-1:0]     mem_bank_q, mem_bank_d;

  logic                  rd_s1_q, rd_s1_d;
  logic                  rd_s2_q, rd_s2_d;
  logic [BANK_W-1:0]     rd_s2_bank_q, rd_s2_bank_d;
  logic [ADDR_WIDTH-1:0] rd_s2_addr_q, rd_s2_addr_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [BANK_W-1:0]     rsp_bank_q, rsp_bank_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  busy_q, busy_d;

  logic                  full_s, empty_s, push_s, pop_s;
  logic                  rsp_drain_s, read_clear_s;
  logic                  head_we_s;
  logic [BANK_W-1:0]     head_bank_s;
  logic [ADDR_WIDTH-1:0] head_addr_s;
  logic [DATA_WIDTH-1:0] head_data_s;

  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == {CNT_W{1'b0}});
  // A same-cycle pop never frees a slot for a same-cycle push.
  assign req_ready = !full_s && !rst;
  assign push_s    = req_valid && req_ready;

  assign head_we_s   = fifo_we_q[rd_ptr_q];
  assign head_bank_s = fifo_bank_q[rd_ptr_q];
  assign head_addr_s = fifo_addr_q[rd_ptr_q];
  assign head_data_s = fifo_data_q[rd_ptr_q];

  // Only one read may be outstanding, and its response slot must be free on capture.
  assign rsp_drain_s  = rsp_valid_q && rsp_ready;
  assign read_clear_s = !rd_s1_q && !rd_s2_q && (!rsp_valid_q || rsp_drain_s);
  assign pop_s        = !empty_s && (head_we_s || read_clear_s);

  // Queue storage; entries need no reset since occupancy gates their use.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_we_q[wr_ptr_q]   <= req_we;
      fifo_bank_q[wr_ptr_q] <= req_bank;
      fifo_addr_q[wr_ptr_q] <= req_addr;
      fifo_data_q[wr_ptr_q] <= req_data;
    end
  end

  // Queue pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue stage: load the memory port from the head entry when it pops.
  always_comb begin
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_bank_d = mem_bank_q;
    rd_s1_d    = 1'b0;
    if (pop_s) begin
      mem_addr_d = head_addr_s;
      mem_bank_d = head_bank_s;
      if (head_we_s) begin
        mem_we_d  = 1'b1;
        mem_din_d = head_data_s;
      end else begin
        rd_s1_d = 1'b1;
      end
    end else begin
      mem_we_d = 1'b0;
    end
  end

  // Read tracking and response slot.
  always_comb begin
    rd_s2_d      = rd_s1_q;
    rd_s2_bank_d = mem_bank_q;
    rd_s2_addr_d = mem_addr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_bank_d   = rsp_bank_q;
    rsp_addr_d   = rsp_addr_q;
    if (rd_s2_q) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = mem_dout;
      rsp_bank_d  = rd_s2_bank_q;
      rsp_addr_d  = rd_s2_addr_q;
    end else if (rsp_drain_s) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
    busy_d = (count_d != {CNT_W{1'b0}}) || rd_s1_d || rd_s2_d || rsp_valid_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_din_q    <= {DATA_WIDTH{1'b0}};
      mem_bank_q   <= {BANK_W{1'b0}};
      rd_s1_q      <= 1'b0;
      rd_s2_q      <= 1'b0;
      rd_s2_bank_q <= {BANK_W{1'b0}};
      rd_s2_addr_q <= {ADDR_WIDTH{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= {DATA_WIDTH{1'b0}};
      rsp_bank_q   <= {BANK_W{1'b0}};
      rsp_addr_q   <= {ADDR_WIDTH{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_bank_q   <= mem_bank_d;
      rd_s1_q      <= rd_s1_d;
      rd_s2_q      <= rd_s2_d;
      rd_s2_bank_q <= rd_s2_bank_d;
      rd_s2_addr_q <= rd_s2_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_bank_q   <= rsp_bank_d;
      rsp_addr_q   <= rsp_addr_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign mem_bank_sel = mem_bank_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_bank     = rsp_bank_q;
  assign rsp_addr     = rsp_addr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_bank_req_sequencer.sv
// Directed bench for bank_req_sequencer with a behavioural registered-read memory.
module tb_bank_req_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [1:0] req_bank;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic [1:0] mem_bank_sel;
  logic [7:0] mem_dout;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_bank;
  logic [3:0] rsp_addr;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] mem_model [4][16];

  bank_req_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_BANKS(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_data(req_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_bank_sel(mem_bank_sel), .mem_dout(mem_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_bank(rsp_bank), .rsp_addr(rsp_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory contents survive reset; read data is registered.
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_bank_sel][mem_addr] <= mem_din;
    mem_dout <= mem_model[mem_bank_sel][mem_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [1:0] bank, input logic [3:0] addr,
                      input logic [7:0] data);
    req_valid = 1'b1;
    req_we    = we;
    req_bank  = bank;
    req_addr  = addr;
    req_data  = data;
    for (int i = 0; i < 50 && !req_ready; i++) tick();
    if (!req_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL push_timeout: req_ready=%0b required 1", req_ready);
    end
    tick();
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_bank = 2'd0;
    req_addr = 4'd0; req_data = 8'd0; rsp_ready = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({mem_we, mem_addr, mem_din, mem_bank_sel} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_mem: got %h required 0", {mem_we, mem_addr, mem_din, mem_bank_sel});
    end
    tests_run++;
    if ({rsp_valid, rsp_data, rsp_bank, rsp_addr} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_rsp: got %h required 0", {rsp_valid, rsp_data, rsp_bank, rsp_addr});
    end
    tests_run++;
    if ({busy, req_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_busy_ready: got %b required 00", {busy, req_ready});
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_bank_isolation();
    logic [7:0] exp_data [4];
    bit ok;
    exp_data[0] = 8'hDE; exp_data[1] = 8'hAD; exp_data[2] = 8'hBE; exp_data[3] = 8'hEF;
    for (int b = 0; b < 4; b++) push(1'b1, 2'(b), 4'h8, exp_data[b]);
    for (int b = 0; b < 4; b++) push(1'b0, 2'(b), 4'h8, 8'h00);
    idle_req();
    for (int b = 0; b < 4; b++) begin
      wait_rsp(ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL bank_rsp_timeout: rsp_valid=%0b required 1 (bank %0d)", rsp_valid, b);
      end
      tests_run++;
      if (rsp_data !== exp_data[b]) begin
        tests_failed++;
        $display("FAIL bank_rsp_data: got %h required %h", rsp_data, exp_data[b]);
      end
      tests_run++;
      if ({rsp_bank, rsp_addr} !== {2'(b), 4'h8}) begin
        tests_failed++;
        $display("FAIL bank_rsp_tag: got bank %0d addr %h required bank %0d addr 8",
                 rsp_bank, rsp_addr, b);
      end
      consume();
    end
  endtask

  task automatic test_queue_full();
    logic [14:0] exp_port;
    bit ok;
    req_valid = 1'b1; req_we = 1'b1;
    req_bank = 2'd0; req_addr = 4'd0; req_data = 8'hA0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k >= 1 && k <= 6) begin
        exp_port = {1'b1, 2'((k - 1) % 4), 4'(k - 1), 8'(8'hA0 + k - 1)};
        tests_run++;
        if ({mem_we, mem_bank_sel, mem_addr, mem_din} !== exp_port) begin
          tests_failed++;
          $display("FAIL b2b_write_%0d: got %h required %h", k,
                   {mem_we, mem_bank_sel, mem_addr, mem_din}, exp_port);
        end
      end else if (k == 7) begin
        tests_run++;
        if (mem_we !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_write_end: mem_we=%0b required 0", mem_we);
        end
      end
      if (k < 5) begin
        req_bank = 2'((k + 1) % 4); req_addr = 4'(k + 1); req_data = 8'(8'hA0 + k + 1);
      end else begin
        req_valid = 1'b0;
      end
    end
    // Stall a read in the response slot, then fill the queue behind a second read.
    push(1'b0, 2'd0, 4'd0, 8'h00);
    push(1'b0, 2'd1, 4'd5, 8'h00);
    push(1'b1, 2'd2, 4'd9, 8'h5A);
    push(1'b1, 2'd2, 4'd10, 8'h5B);
    push(1'b1, 2'd2, 4'd11, 8'h5C);
    req_valid = 1'b1; req_we = 1'b1; req_bank = 2'd2; req_addr = 4'd12; req_data = 8'h5D;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL full_ready_%0d: req_ready=%0b required 0", i, req_ready);
      end
      tick();
    end
    tests_run++;
    if ({mem_we, rsp_valid, rsp_data} !== {1'b0, 1'b1, 8'hA0}) begin
      tests_failed++;
      $display("FAIL full_stalled_state: got %h required 1a0", {mem_we, rsp_valid, rsp_data});
    end
    consume();
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_ready_after_drain: req_ready=%0b required 1", req_ready);
    end
    tick();
    idle_req();
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL full_second_read: valid %0b data %h required 1 a5", rsp_valid, rsp_data);
    end
    consume();
    push(1'b0, 2'd2, 4'd12, 8'h00);
    idle_req();
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_data !== 8'h5D) begin
      tests_failed++;
      $display("FAIL full_held_write: valid %0b data %h required 1 5d", rsp_valid, rsp_data);
    end
    consume();
  endtask

  task automatic test_backpressure();
    bit ok;
    push(1'b1, 2'd1, 4'd5, 8'h55);
    push(1'b0, 2'd1, 4'd5, 8'h00);
    push(1'b0, 2'd1, 4'd5, 8'h00);
    idle_req();
    wait_rsp(ok);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({rsp_valid, rsp_data, rsp_bank, rsp_addr} !== {1'b1, 8'h55, 2'd1, 4'd5}) begin
        tests_failed++;
        $display("FAIL bp_stable_%0d: got %h required %h", i,
                 {rsp_valid, rsp_data, rsp_bank, rsp_addr}, {1'b1, 8'h55, 2'd1, 4'd5});
      end
      tick();
    end
    consume();
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain_c0: rsp_valid=%0b required 0", rsp_valid);
    end
    tick();
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain_c1: rsp_valid=%0b required 0", rsp_valid);
    end
    tick();
    tests_run++;
    if ({rsp_valid, rsp_data} !== {1'b1, 8'h55}) begin
      tests_failed++;
      $display("FAIL bp_second: got %h required 155", {rsp_valid, rsp_data});
    end
    consume();
  endtask

  task automatic test_boundaries();
    bit ok;
    push(1'b1, 2'd3, 4'h0, 8'h11);
    push(1'b1, 2'd3, 4'hF, 8'hFF);
    push(1'b0, 2'd3, 4'h0, 8'h00);
    idle_req();
    wait_rsp(ok);
    tests_run++;
    if (!ok || {rsp_data, rsp_addr} !== {8'h11, 4'h0}) begin
      tests_failed++;
      $display("FAIL bnd_addr0: got %h required 110", {rsp_data, rsp_addr});
    end
    consume();
    // Lone read from idle: response appears exactly three edges after acceptance.
    push(1'b0, 2'd3, 4'hF, 8'h00);
    idle_req();
    tick();
    tick();
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_latency_early: rsp_valid=%0b required 0", rsp_valid);
    end
    tick();
    tests_run++;
    if ({rsp_valid, rsp_data, rsp_addr} !== {1'b1, 8'hFF, 4'hF}) begin
      tests_failed++;
      $display("FAIL bnd_addrF: got %h required 1fff", {rsp_valid, rsp_data, rsp_addr});
    end
    consume();
    push(1'b1, 2'd2, 4'h3, 8'hAA);
    push(1'b0, 2'd2, 4'h3, 8'h00);
    idle_req();
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_data !== 8'hAA) begin
      tests_failed++;
      $display("FAIL raw_same_addr: got %h required aa", rsp_data);
    end
    consume();
  endtask

  task automatic test_reset_during_read();
    bit ok;
    bit seen;
    push(1'b1, 2'd1, 4'h2, 8'h77);
    idle_req();
    tick();
    tests_run++;
    if (mem_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_write_onport: mem_we=%0b required 1", mem_we);
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    push(1'b0, 2'd0, 4'h8, 8'h00);
    idle_req();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_no_rsp: rsp_valid rose=%0b required 0", seen);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_busy: busy=%0b required 0", busy);
    end
    push(1'b0, 2'd2, 4'h8, 8'h00);
    idle_req();
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_data !== 8'hBE) begin
      tests_failed++;
      $display("FAIL rst_read_after: got %h required be", rsp_data);
    end
    consume();
    push(1'b0, 2'd1, 4'h2, 8'h00);
    idle_req();
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_data !== 8'h77) begin
      tests_failed++;
      $display("FAIL rst_write_completed: got %h required 77", rsp_data);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_bank_isolation();
    test_queue_full();
    test_backpressure();
    test_boundaries();
    test_reset_during_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
